// File: rtl/secded_enc_tx.sv
// SECDED (8,4) transmit encoder: builds the Hamming+global-parity codeword, optionally
// flips bits from an injection mask, then serialises it LSB first under valid/ready.
module secded_enc_tx #(
    parameter int BIT_CYCLES = 1,
    parameter bit INJECT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] data_in,
    input  logic [7:0] err_mask,
    output logic [7:0] code_word,
    output logic [3:0] inj_count,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       tx_done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    mask_eff;
    logic [7:0]    next_word;
    logic          accept;

    // Layout g0 w3 w2 w1 p2 w0 p1 p0 matches the receive-side corrector.
    function automatic logic [7:0] encode(input logic [3:0] w);
        logic [6:0] h;
        h = {w[3], w[2], w[1], w[1] ^ w[2] ^ w[3], w[0],
             w[0] ^ w[2] ^ w[3], w[0] ^ w[1] ^ w[3]};
        return {^h, h};
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, m[i]};
        return n;
    endfunction

    always_comb begin
        mask_eff  = INJECT_EN ? err_mask : 8'h00;
        next_word = encode(data_in) ^ mask_eff;
        accept    = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            code_word <= 8'h00;
            inj_count <= 4'd0;
            tx_bit    <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SEND;
                        code_word <= next_word;
                        inj_count <= popcount(mask_eff);
                        idx       <= '0;
                        cnt       <= '0;
                        tx_bit    <= next_word[0];
                        tx_active <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                SEND: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            state     <= DONE;
                            tx_bit    <= 1'b0;
                            tx_active <= 1'b0;
                            tx_done   <= 1'b1;
                        end else begin
                            idx    <= idx + 3'd1;
                            tx_bit <= code_word[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Ready rises as we leave, so a held in_valid is taken in the first IDLE cycle.
                    state    <= IDLE;
                    tx_done  <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    tx_bit    <= 1'b0;
                    tx_active <= 1'b0;
                    tx_done   <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_secded_enc_tx.sv
// Scoreboard bench for secded_enc_tx: three instances (BIT_CYCLES=1, INJECT_EN=0, BIT_CYCLES=3)
// exercised one at a time; a negedge monitor deserialises each frame and checks it.
module tb_secded_enc_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid  [3];
    logic [3:0] data_in   [3];
    logic [7:0] err_mask  [3];
    logic       in_ready  [3];
    logic [7:0] code_word [3];
    logic [3:0] inj_count [3];
    logic       tx_bit    [3];
    logic       tx_active [3];
    logic       tx_done   [3];

    secded_enc_tx #(.BIT_CYCLES(1), .INJECT_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data_in(data_in[0]), .err_mask(err_mask[0]), .code_word(code_word[0]),
        .inj_count(inj_count[0]), .tx_bit(tx_bit[0]), .tx_active(tx_active[0]), .tx_done(tx_done[0]));
    secded_enc_tx #(.BIT_CYCLES(1), .INJECT_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data_in(data_in[1]), .err_mask(err_mask[1]), .code_word(code_word[1]),
        .inj_count(inj_count[1]), .tx_bit(tx_bit[1]), .tx_active(tx_active[1]), .tx_done(tx_done[1]));
    secded_enc_tx #(.BIT_CYCLES(3), .INJECT_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .data_in(data_in[2]), .err_mask(err_mask[2]), .code_word(code_word[2]),
        .inj_count(inj_count[2]), .tx_bit(tx_bit[2]), .tx_active(tx_active[2]), .tx_done(tx_done[2]));

    typedef struct {
        int         kind;   // 0: exact codeword, 1: decode through corrector model
        logic [7:0] code;
        logic [3:0] inj;
        logic [3:0] data;
        logic       dbl;
        int         acc;
        int         d;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bc_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    // Receive-side reference corrector: returns {dbl, data}.
    function automatic logic [4:0] decode(input logic [7:0] c);
        logic [7:0] cc;
        logic [2:0] syn;
        logic       dbl;
        cc  = c;
        dbl = 1'b0;
        syn = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
        if (^c) begin
            if (syn != 3'd0) cc[int'(syn) - 1] = ~cc[int'(syn) - 1];
        end else if (syn != 3'd0) begin
            dbl = 1'b1;
        end
        return {dbl, cc[6], cc[5], cc[4], cc[2]};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
    endtask

    function automatic exp_t mk0(input logic [7:0] code, input logic [3:0] inj);
        exp_t e;
        e = '{kind: 0, code: code, inj: inj, data: 4'd0, dbl: 1'b0, acc: 0, d: 0};
        return e;
    endfunction

    function automatic exp_t mk1(input logic [3:0] data, input logic [3:0] inj, input logic dbl);
        exp_t e;
        e = '{kind: 1, code: 8'h00, inj: inj, data: data, dbl: dbl, acc: 0, d: 0};
        return e;
    endfunction

    task automatic send(input int d, input logic [3:0] data, input logic [7:0] mask,
                        input bit push, input exp_t e);
        exp_t ee;
        ee = e;
        @(negedge clk);
        data_in[d]  = data;
        err_mask[d] = mask;
        in_valid[d] = 1'b1;
        for (int i = 0; i < 100 && !in_ready[d]; i++) @(negedge clk);
        if (!in_ready[d]) check($sformatf("ready_timeout_dut%0d", d), 0, 1);
        ee.acc = cyc + 1;
        ee.d   = d;
        if (push) sb.push_back(ee);
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor
    int         act_cnt [3];
    int         lo_cnt  [3];
    logic [23:0] sbits  [3];

    initial begin
        exp_t       e;
        logic [7:0] sw;
        logic [4:0] dc, ds;
        int         bc, herr;
        for (int d = 0; d < 3; d++) begin act_cnt[d] = 0; lo_cnt[d] = 0; sbits[d] = '0; end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    act_cnt[d] = 0;
                    lo_cnt[d]  = 0;
                end else begin
                    if (!in_ready[d]) lo_cnt[d]++;
                    else lo_cnt[d] = 0;
                    if (tx_active[d]) begin
                        if (act_cnt[d] < 24) sbits[d][act_cnt[d]] = tx_bit[d];
                        act_cnt[d]++;
                    end
                    if (tx_done[d]) begin
                        if (sb.size() == 0) begin
                            check($sformatf("unexpected_done_dut%0d", d), 1, 0);
                        end else begin
                            e  = sb.pop_front();
                            bc = bc_of(d);
                            check($sformatf("frame_dut%0d", d), d, e.d);
                            check("done_latency", cyc - e.acc, 8 * bc);
                            check("active_cycles", act_cnt[d], 8 * bc);
                            check("ready_low_cycles", lo_cnt[d], 8 * bc + 1);
                            herr = 0;
                            for (int i = 0; i < 8; i++) begin
                                sw[i] = sbits[d][i * bc];
                                for (int j = 0; j < bc; j++)
                                    if (sbits[d][i * bc + j] != sw[i]) herr++;
                            end
                            check("bit_hold", herr, 0);
                            check("inj_count", int'(inj_count[d]), int'(e.inj));
                            if (e.kind == 0) begin
                                check("code_word", int'(code_word[d]), int'(e.code));
                                check("serial_word", int'(sw), int'(e.code));
                            end else begin
                                dc = decode(code_word[d]);
                                ds = decode(sw);
                                check("dbl_flag", int'(dc[4]), int'(e.dbl));
                                check("serial_dbl_flag", int'(ds[4]), int'(e.dbl));
                                if (!e.dbl) begin
                                    check("corrected_data", int'(dc[3:0]), int'(e.data));
                                    check("serial_corrected", int'(ds[3:0]), int'(e.data));
                                end
                            end
                        end
                        act_cnt[d] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       dummy;
        logic [7:0] m;
        int         a, b;
        dummy = mk0(8'h00, 4'd0);
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; data_in[d] = 4'd0; err_mask[d] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_code_word_dut%0d", d), int'(code_word[d]), 0);
            check("rst_inj_count", int'(inj_count[d]), 0);
            check("rst_tx_bit", int'(tx_bit[d]), 0);
            check("rst_tx_active", int'(tx_active[d]), 0);
            check("rst_tx_done", int'(tx_done[d]), 0);
            check("rst_in_ready", int'(in_ready[d]), 1);
        end
        rst = 1'b0;

        // Clean codewords
        send(0, 4'b1011, 8'h00, 1, mk0(8'h55, 4'd0));
        send(0, 4'b0001, 8'h00, 1, mk0(8'h87, 4'd0));
        send(0, 4'b1111, 8'h00, 1, mk0(8'hFF, 4'd0));
        send(0, 4'b0000, 8'h00, 1, mk0(8'h00, 4'd0));
        drain();

        // Injection
        send(0, 4'b1011, 8'h04, 1, mk0(8'h51, 4'd1));
        send(0, 4'b1011, 8'h80, 1, mk0(8'hD5, 4'd1));
        send(0, 4'b1011, 8'h06, 1, mk0(8'h53, 4'd2));
        send(1, 4'b1011, 8'hFF, 1, mk0(8'h55, 4'd0));
        drain();

        // Slow bit rate, with ignored mid-frame valid and data changes
        send(2, 4'b0001, 8'h00, 1, mk0(8'h87, 4'd0));
        repeat (5) @(negedge clk);
        data_in[2] = 4'hF; err_mask[2] = 8'hFF; in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (6) @(negedge clk);
        in_valid[2] = 1'b1;
        @(negedge clk);
        in_valid[2] = 1'b0;
        drain();
        check("mid_frame_code_hold", int'(code_word[2]), 'h87);

        // Reset at bit 4 aborts the frame
        send(0, 4'b1011, 8'h00, 0, dummy);
        repeat (4) @(negedge clk);
        check("pre_abort_tx_active", int'(tx_active[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_active", int'(tx_active[0]), 0);
        check("abort_tx_bit", int'(tx_bit[0]), 0);
        check("abort_code_word", int'(code_word[0]), 0);
        check("abort_tx_done", int'(tx_done[0]), 0);
        check("abort_in_ready", int'(in_ready[0]), 1);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        send(0, 4'b0001, 8'h00, 1, mk0(8'h87, 4'd0));
        drain();

        // All data values through the corrector model: single then double errors
        for (int v = 0; v < 16; v++) begin
            m = 8'h01 << $urandom_range(7, 0);
            send(0, 4'(v), m, 1, mk1(4'(v), 4'd1, 1'b0));
            a = $urandom_range(6, 0);
            b = (a + 1 + $urandom_range(5, 0)) % 7;
            m = (8'h01 << a) | (8'h01 << b);
            send(0, 4'(v), m, 1, mk1(4'(v), 4'd2, 1'b1));
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
